// File: rtl/blink_seq_ctrl.sv
// LED pattern sequencer: latches a pattern/rate/repeat configuration in IDLE,
// steps the LED register at the programmed rate and pulses done after N repetitions.
//
//  state  | meaning
//  IDLE   | waiting for start; configuration accepted; out holds last value
//  RUN    | stepping the pattern at the programmed rate
//  DONE   | single-cycle completion pulse, then back to IDLE
module blink_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [7:0]       cfg_reps,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int SW = WIDTH + 1;

    localparam logic [1:0] MODE_BLINK    = 2'd0;
    localparam logic [1:0] MODE_CHASE    = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_COUNT    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] out_q, out_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [7:0]       reps_q, reps_nxt;
    logic [DIV_W-1:0] prescale, prescale_nxt;
    logic [SW-1:0]    step_left, step_left_nxt;
    logic [7:0]       rep_cnt, rep_cnt_nxt;
    logic             dir_up, dir_up_nxt;
    logic             tick_q, tick_nxt;

    logic [1:0]       run_mode;
    logic [WIDTH-1:0] pat_nxt;
    logic [7:0]       rep_inc;
    logic             step_hit;

    function automatic logic [WIDTH-1:0] first_pattern(input logic [1:0] m);
        first_pattern = (m == MODE_CHASE || m == MODE_PINGPONG) ? WIDTH'(1) : '0;
    endfunction

    // Steps in one repetition, minus one: the step counter runs down to zero.
    function automatic logic [SW-1:0] rep_len_m1(input logic [1:0] m);
        unique case (m)
            MODE_BLINK:    rep_len_m1 = SW'(1);
            MODE_CHASE:    rep_len_m1 = SW'(WIDTH - 1);
            MODE_PINGPONG: rep_len_m1 = SW'(2 * WIDTH - 3);
            default:       rep_len_m1 = {1'b0, {WIDTH{1'b1}}};
        endcase
    endfunction

    assign step_hit = (prescale == div_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_q     <= '0;
            mode_q    <= '0;
            div_q     <= '0;
            reps_q    <= '0;
            prescale  <= '0;
            step_left <= '0;
            rep_cnt   <= '0;
            dir_up    <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_q     <= out_nxt;
            mode_q    <= mode_nxt;
            div_q     <= div_nxt;
            reps_q    <= reps_nxt;
            prescale  <= prescale_nxt;
            step_left <= step_left_nxt;
            rep_cnt   <= rep_cnt_nxt;
            dir_up    <= dir_up_nxt;
            tick_q    <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        out_nxt       = out_q;
        mode_nxt      = mode_q;
        div_nxt       = div_q;
        reps_nxt      = reps_q;
        prescale_nxt  = prescale;
        step_left_nxt = step_left;
        rep_cnt_nxt   = rep_cnt;
        dir_up_nxt    = dir_up;
        tick_nxt      = 1'b0;
        run_mode      = mode_q;
        pat_nxt       = out_q;
        rep_inc       = rep_cnt + 8'd1;

        unique case (mode_q)
            MODE_BLINK: pat_nxt = ~out_q;
            MODE_CHASE: pat_nxt = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            MODE_PINGPONG: begin
                if (dir_up) begin
                    pat_nxt = out_q << 1;
                    if (pat_nxt[WIDTH-1]) dir_up_nxt = 1'b0;
                end else begin
                    pat_nxt = out_q >> 1;
                    if (pat_nxt[0]) dir_up_nxt = 1'b1;
                end
            end
            default: pat_nxt = out_q + WIDTH'(1);
        endcase

        unique case (state)
            S_IDLE: begin
                dir_up_nxt = dir_up;
                if (cfg_valid) begin
                    mode_nxt = cfg_mode;
                    div_nxt  = cfg_div;
                    reps_nxt = cfg_reps;
                    run_mode = cfg_mode;
                end
                if (start) begin
                    state_nxt     = S_RUN;
                    out_nxt       = first_pattern(run_mode);
                    prescale_nxt  = '0;
                    rep_cnt_nxt   = '0;
                    step_left_nxt = rep_len_m1(run_mode);
                    dir_up_nxt    = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nxt  = S_IDLE;
                    out_nxt    = '0;
                    dir_up_nxt = dir_up;
                end else if (step_hit) begin
                    prescale_nxt = '0;
                    out_nxt      = pat_nxt;
                    tick_nxt     = 1'b1;
                    if (step_left == '0) begin
                        step_left_nxt = rep_len_m1(mode_q);
                        rep_cnt_nxt   = rep_inc;
                        if (reps_q != 8'd0 && rep_inc == reps_q) state_nxt = S_DONE;
                    end else begin
                        step_left_nxt = step_left - SW'(1);
                    end
                end else begin
                    prescale_nxt = prescale + DIV_W'(1);
                    dir_up_nxt   = dir_up;
                end
            end
            S_DONE: begin
                dir_up_nxt = dir_up;
                state_nxt  = S_IDLE;
            end
            default: begin
                dir_up_nxt = dir_up;
                state_nxt  = S_IDLE;
            end
        endcase
    end

    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign tick      = tick_q;
    assign out       = out_q;

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// Bench for blink_seq_ctrl: a fixed vector table, directed multi-cycle sequences
// and random traffic, all compared against a step-index reference model.
module tb_blink_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, cfg_valid, cfg_ready, start, stop, busy, tick, done;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_div;
    logic [7:0]  cfg_reps;
    logic [7:0]  out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    blink_seq_ctrl #(.WIDTH(8), .DIV_W(24)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_reps(cfg_reps),
        .start(start), .stop(stop), .busy(busy), .tick(tick), .done(done), .out(out)
    );

    typedef struct {
        bit        rst, cv;
        bit [1:0]  mode;
        bit [23:0] div;
        bit [7:0]  reps;
        bit        st, sp;
    } in_t;

    typedef struct {
        in_t         in;
        logic [11:0] exp;   // {cfg_ready, busy, tick, done, out}
    } vec_t;

    vec_t tbl[$];

    // Reference model: tracks clocks since start; the pattern is a function of step index.
    bit     m_run, m_done, m_tick;
    bit [7:0] m_out;
    int     m_mode;
    longint m_div, m_reps, m_c;

    function automatic in_t mk(bit rst, bit cv, bit [1:0] m, int d, int r, bit st, bit sp);
        in_t v;
        v.rst = rst; v.cv = cv; v.mode = m; v.div = 24'(d); v.reps = 8'(r);
        v.st = st; v.sp = sp;
        return v;
    endfunction

    function automatic longint rep_len(int m);
        case (m)
            0: return 2;
            1: return 8;
            2: return 14;
            default: return 256;
        endcase
    endfunction

    function automatic bit [7:0] pattern(int m, longint k);
        longint j;
        case (m)
            0: return (k % 2 == 1) ? 8'hFF : 8'h00;
            1: return 8'(1 << (k % 8));
            2: begin
                j = k % 14;
                return (j < 8) ? 8'(1 << j) : 8'(1 << (14 - j));
            end
            default: return 8'(k % 256);
        endcase
    endfunction

    task automatic model_edge(input in_t v);
        longint k;
        m_tick = 0;
        if (v.rst) begin
            m_run = 0; m_done = 0; m_out = 0; m_mode = 0; m_div = 0; m_reps = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (v.cv) begin
                m_mode = int'(v.mode); m_div = longint'(v.div); m_reps = longint'(v.reps);
            end
            if (v.st) begin
                m_run = 1; m_c = 0; m_out = pattern(m_mode, 0);
            end
        end else if (v.sp) begin
            m_run = 0; m_out = 0;
        end else begin
            m_c++;
            if (m_c % (m_div + 1) == 0) begin
                k = m_c / (m_div + 1);
                m_out = pattern(m_mode, k);
                m_tick = 1;
                if (m_reps != 0 && k == m_reps * rep_len(m_mode)) begin
                    m_run = 0; m_done = 1;
                end
            end
        end
    endtask

    function automatic logic [11:0] model_exp();
        return {!m_run && !m_done, m_run, m_tick, m_done, m_out};
    endfunction

    task automatic apply(input in_t v, output logic [11:0] act);
        reset = v.rst; cfg_valid = v.cv; cfg_mode = v.mode; cfg_div = v.div;
        cfg_reps = v.reps; start = v.st; stop = v.sp;
        @(posedge clk);
        model_edge(v);
        #1;
        act = {cfg_ready, busy, tick, done, out};
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h ({ready,busy,tick,done,out})", name, act, exp);
        end
    endtask

    task automatic run_model(input string name, input in_t v);
        logic [11:0] act;
        apply(v, act);
        check(name, act, model_exp());
    endtask

    task automatic add(input in_t i, input logic [11:0] e);
        vec_t r;
        r.in = i; r.exp = e;
        tbl.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] act;
        in_t idle;
        int ticks, dones, done_at;
        idle = mk(0, 0, 0, 0, 0, 0, 0);

        // Reset while running (BLINK, div 0).
        add(mk(1, 0, 0, 0, 0, 0, 0), 12'h800);
        add(mk(0, 1, 0, 0, 0, 0, 0), 12'h800);
        add(mk(0, 0, 0, 0, 0, 1, 0), 12'h400);
        add(idle, 12'h6FF);
        add(idle, 12'h600);
        add(idle, 12'h6FF);
        add(idle, 12'h600);
        add(idle, 12'h6FF);
        add(mk(1, 0, 0, 0, 0, 0, 0), 12'h800);
        add(idle, 12'h800);
        // Stop on a step edge beats the step; restart replays from P0.
        add(mk(0, 1, 0, 2, 0, 0, 0), 12'h800);
        add(mk(0, 0, 0, 0, 0, 1, 0), 12'h400);
        add(idle, 12'h400);
        add(idle, 12'h400);
        add(mk(0, 0, 0, 0, 0, 0, 1), 12'h800);
        add(mk(0, 0, 0, 0, 0, 1, 0), 12'h400);
        add(idle, 12'h400);
        add(idle, 12'h400);
        add(idle, 12'h6FF);
        add(idle, 12'h4FF);
        add(idle, 12'h4FF);
        add(mk(0, 0, 0, 0, 0, 0, 1), 12'h800);
        // Stop ignored in IDLE; start wins over stop in IDLE.
        add(mk(0, 0, 0, 0, 0, 0, 1), 12'h800);
        add(mk(0, 0, 0, 0, 0, 1, 1), 12'h400);
        add(mk(0, 0, 0, 0, 0, 0, 1), 12'h800);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].in, act);
            check($sformatf("table[%0d]", i), act, tbl[i].exp);
        end

        // BLINK div 3, 2 reps: four steps 4 clocks apart, done on the fourth.
        ticks = 0; dones = 0; done_at = -1;
        run_model("blink_start", mk(0, 1, 0, 3, 2, 1, 0));
        for (int i = 1; i <= 20; i++) begin
            apply(idle, act);
            check($sformatf("blink[%0d]", i), act, model_exp());
            if (tick) ticks++;
            if (done) begin dones++; done_at = i; end
        end
        check("blink_tick_count", 12'(ticks), 12'd4);
        check("blink_done_count", 12'(dones), 12'd1);
        check("blink_done_cycle", 12'(done_at), 12'd16);

        // CHASE and PINGPONG, single repetition, div 0.
        run_model("chase_start", mk(0, 1, 1, 0, 1, 1, 0));
        for (int i = 1; i <= 12; i++) run_model($sformatf("chase[%0d]", i), idle);
        run_model("pp_start", mk(0, 1, 2, 0, 1, 1, 0));
        for (int i = 1; i <= 18; i++) run_model($sformatf("pp[%0d]", i), idle);

        // COUNT with config in the start cycle; config offered mid-run is refused.
        run_model("count_start", mk(0, 1, 3, 0, 0, 1, 0));
        for (int i = 1; i <= 4; i++) run_model($sformatf("count[%0d]", i), idle);
        run_model("cfg_in_run", mk(0, 1, 1, 5, 3, 0, 0));
        for (int i = 1; i <= 4; i++) run_model($sformatf("count_after_cfg[%0d]", i), idle);
        run_model("count_stop", mk(0, 0, 0, 0, 0, 0, 1));

        // COUNT single repetition: 256 steps must not wrap the step counter early.
        run_model("count_rep_start", mk(0, 1, 3, 0, 1, 1, 0));
        for (int i = 1; i <= 260; i++) run_model($sformatf("count_rep[%0d]", i), idle);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            in_t v;
            v.rst  = ($urandom_range(0, 199) == 0);
            v.cv   = ($urandom_range(0, 3) == 0);
            v.mode = 2'($urandom_range(0, 3));
            v.div  = 24'($urandom_range(0, 3));
            v.reps = 8'($urandom_range(0, 3));
            v.st   = ($urandom_range(0, 7) == 0);
            v.sp   = ($urandom_range(0, 29) == 0);
            run_model($sformatf("rand[%0d]", i), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
